// File: rtl/regfile_fwd_if.sv
// Purpose: bundles the read ports, EX/MEM/WB write-back buses and stall outputs of regfile_fwd.
// Latency: none, signal bundle only.
// Backpressure: none; stall_req is the only hold indication toward ID/IF.
interface regfile_fwd_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 16
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     ex_wr_en;
  logic [ADDR_W-1:0]        ex_wr_addr;
  logic [DATA_W-1:0]        ex_wr_data;
  logic                     ex_is_load;
  logic                     mem_wr_en;
  logic [ADDR_W-1:0]        mem_wr_addr;
  logic [DATA_W-1:0]        mem_wr_data;
  logic                     wb_wr_en;
  logic [ADDR_W-1:0]        wb_wr_addr;
  logic [DATA_W-1:0]        wb_wr_data;
  logic                     stall_req;
  logic [CNT_W-1:0]         stall_cnt;

  // Pipeline side: drives addresses and stage results, consumes read data and stall.
  modport master (
    output rd_en, rd_addr,
    output ex_wr_en, ex_wr_addr, ex_wr_data, ex_is_load,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output wb_wr_en, wb_wr_addr, wb_wr_data,
    input  rd_data, stall_req, stall_cnt
  );

  // Register file side.
  modport slave (
    input  rd_en, rd_addr,
    input  ex_wr_en, ex_wr_addr, ex_wr_data, ex_is_load,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  wb_wr_en, wb_wr_addr, wb_wr_data,
    output rd_data, stall_req, stall_cnt
  );
endinterface

// File: rtl/regfile_fwd.sv
// Purpose: multi-read-port register file with EX->MEM->WB forwarding and load-use stall detection.
// Latency: reads and stall_req are combinational; WB commit and stall_cnt update at the clk edge.
// Backpressure: none accepted; stall_req asks ID/IF to hold while an EX load feeds a live read.
module regfile_fwd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,   // active-high synchronous reset despite the legacy name
  regfile_fwd_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [NUM_RD-1:0] hazard;

  // Array commit from WB; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (bus.wb_wr_en && (bus.wb_wr_addr != '0)) begin
      regs[bus.wb_wr_addr] <= bus.wb_wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              live;
    logic [DATA_W-1:0] val;

    assign addr = bus.rd_addr[g*ADDR_W +: ADDR_W];
    // Port is quiet during reset, when disabled, or when it addresses r0.
    assign live = !rst_n && bus.rd_en[g] && (addr != '0);

    // Youngest producer wins; an EX load has no data yet so it falls through.
    always_comb begin
      val = regs[addr];
      if (bus.ex_wr_en && !bus.ex_is_load && (bus.ex_wr_addr == addr)) begin
        val = bus.ex_wr_data;
      end else if (bus.mem_wr_en && (bus.mem_wr_addr == addr)) begin
        val = bus.mem_wr_data;
      end else if (bus.wb_wr_en && (bus.wb_wr_addr == addr)) begin
        val = bus.wb_wr_data;
      end
    end

    assign bus.rd_data[g*DATA_W +: DATA_W] = live ? val : '0;
    assign hazard[g] = live && bus.ex_wr_en && bus.ex_is_load && (bus.ex_wr_addr == addr);
  end

  assign bus.stall_req = |hazard;

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt <= '0;
    end else if (bus.stall_req && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_regfile_fwd.sv
`timescale 1ns/1ps
// Bench for regfile_fwd: directed table and sequences, then random traffic against a reference model.
module tb_regfile_fwd;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(16)) bus ();
  regfile_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(4))  bus4 ();

  regfile_fwd #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  regfile_fwd #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  // The narrow-counter instance sees exactly the same traffic.
  assign bus4.rd_en       = bus.rd_en;
  assign bus4.rd_addr     = bus.rd_addr;
  assign bus4.ex_wr_en    = bus.ex_wr_en;
  assign bus4.ex_wr_addr  = bus.ex_wr_addr;
  assign bus4.ex_wr_data  = bus.ex_wr_data;
  assign bus4.ex_is_load  = bus.ex_is_load;
  assign bus4.mem_wr_en   = bus.mem_wr_en;
  assign bus4.mem_wr_addr = bus.mem_wr_addr;
  assign bus4.mem_wr_data = bus.mem_wr_data;
  assign bus4.wb_wr_en    = bus.wb_wr_en;
  assign bus4.wb_wr_addr  = bus.wb_wr_addr;
  assign bus4.wb_wr_data  = bus.wb_wr_data;

  int checks = 0;
  int failures = 0;

  // Reference state: architectural register contents and the two stall counters.
  logic [DW-1:0] m_regs [32];
  int            m_cnt16;
  int            m_cnt4;

  typedef struct {
    logic        ex_en;
    logic        ex_ld;
    logic        mem_en;
    logic        wb_en;
    logic [31:0] exp_data;
    logic        exp_stall;
  } fwd_vec_t;

  fwd_vec_t fwd_tab [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] port_addr(int p);
    logic [NR*AW-1:0] v;
    v = bus.rd_addr;
    return v[p*AW +: AW];
  endfunction

  // Value ID should see on port p, straight from the forwarding rules.
  function automatic logic [31:0] m_rd(int p);
    logic [4:0] a;
    a = port_addr(p);
    if (rst_n || !bus.rd_en[p] || a == 5'd0) return 32'd0;
    if (bus.ex_wr_en && !bus.ex_is_load && bus.ex_wr_addr == a) return bus.ex_wr_data;
    if (bus.mem_wr_en && bus.mem_wr_addr == a) return bus.mem_wr_data;
    if (bus.wb_wr_en && bus.wb_wr_addr == a) return bus.wb_wr_data;
    return m_regs[a];
  endfunction

  function automatic logic m_stall();
    logic s;
    s = 1'b0;
    for (int p = 0; p < NR; p++) begin
      if (!rst_n && bus.rd_en[p] && port_addr(p) != 5'd0 && bus.ex_wr_en &&
          bus.ex_is_load && bus.ex_wr_addr == port_addr(p)) s = 1'b1;
    end
    return s;
  endfunction

  // Advance the model with the inputs currently applied, then cross the clock edge.
  task automatic tick();
    if (rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      if (m_stall()) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (bus.wb_wr_en && bus.wb_wr_addr != 5'd0) m_regs[bus.wb_wr_addr] = bus.wb_wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_check(input string tag);
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("%s_rd%0d", tag, p), bus.rd_data[p*DW +: DW], m_rd(p));
      chk($sformatf("%s_rd%0d_n", tag, p), bus4.rd_data[p*DW +: DW], m_rd(p));
    end
    chk({tag, "_stall"}, {31'd0, bus.stall_req}, {31'd0, m_stall()});
    chk({tag, "_cnt16"}, {16'd0, bus.stall_cnt}, m_cnt16);
    chk({tag, "_cnt4"}, {28'd0, bus4.stall_cnt}, m_cnt4);
  endtask

  task automatic idle();
    bus.rd_en       = '0;
    bus.rd_addr     = '0;
    bus.ex_wr_en    = 1'b0;
    bus.ex_wr_addr  = '0;
    bus.ex_wr_data  = '0;
    bus.ex_is_load  = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.wb_wr_en    = 1'b0;
    bus.wb_wr_addr  = '0;
    bus.wb_wr_data  = '0;
  endtask

  task automatic set_addr(input int p, input logic [4:0] a);
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  initial begin
    // Forwarding priority vectors on r7 (array=1, wb=2, mem=3, ex=4); wb rows commit 2 to the array.
    fwd_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0};
    fwd_tab[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd4, 1'b0};
    fwd_tab[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0};
    fwd_tab[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0};
    fwd_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 1'b1};
    fwd_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 1'b1};

    idle();
    rst_n = 1'b1;
    bus.rd_en = '1;
    set_addr(0, 5'd1);
    set_addr(1, 5'd2);
    @(negedge clk);
    chk("rst_rd0_in_reset", bus.rd_data[0 +: DW], 32'd0);
    tick();
    tick();

    // Out of reset: everything reads zero.
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rd0", bus.rd_data[0 +: DW], 32'd0);
    chk("rst_rd1", bus.rd_data[DW +: DW], 32'd0);
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("rst_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    tick();

    // WB write-through, then readback from the array.
    bus.rd_en = 2'b01;
    set_addr(0, 5'd5);
    bus.wb_wr_en = 1'b1; bus.wb_wr_addr = 5'd5; bus.wb_wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("wb_bypass", bus.rd_data[0 +: DW], 32'hDEADBEEF);
    tick();
    bus.wb_wr_en = 1'b0;
    @(negedge clk);
    chk("wb_array", bus.rd_data[0 +: DW], 32'hDEADBEEF);
    tick();

    // Forwarding priority table.
    bus.wb_wr_en = 1'b1; bus.wb_wr_addr = 5'd7; bus.wb_wr_data = 32'd1;
    tick();
    bus.rd_en = 2'b11;
    set_addr(0, 5'd7);
    set_addr(1, 5'd7);
    bus.ex_wr_addr = 5'd7;  bus.ex_wr_data = 32'd4;
    bus.mem_wr_addr = 5'd7; bus.mem_wr_data = 32'd3;
    bus.wb_wr_addr = 5'd7;  bus.wb_wr_data = 32'd2;
    for (int r = 0; r < 6; r++) begin
      bus.ex_wr_en  = fwd_tab[r].ex_en;
      bus.ex_is_load = fwd_tab[r].ex_ld;
      bus.mem_wr_en = fwd_tab[r].mem_en;
      bus.wb_wr_en  = fwd_tab[r].wb_en;
      @(negedge clk);
      chk($sformatf("fwd%0d_rd0", r), bus.rd_data[0 +: DW], fwd_tab[r].exp_data);
      chk($sformatf("fwd%0d_rd1", r), bus.rd_data[DW +: DW], fwd_tab[r].exp_data);
      chk($sformatf("fwd%0d_stall", r), {31'd0, bus.stall_req}, {31'd0, fwd_tab[r].exp_stall});
      tick();
    end

    // Load-use on port1 held three cycles; the table already produced two stall cycles.
    idle();
    bus.rd_en = 2'b10;
    set_addr(1, 5'd9);
    bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_wr_addr = 5'd9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("lu_stall%0d", c), {31'd0, bus.stall_req}, 32'd1);
      tick();
    end
    @(negedge clk);
    chk("lu_cnt16", {16'd0, bus.stall_cnt}, 32'd5);
    chk("lu_cnt4", {28'd0, bus4.stall_cnt}, 32'd5);
    set_addr(1, 5'd10);
    #1;
    chk("lu_other_addr", {31'd0, bus.stall_req}, 32'd0);
    tick();

    // Register zero: never written, forwarded or stalled on.
    idle();
    bus.rd_en = 2'b11;
    bus.wb_wr_en = 1'b1; bus.wb_wr_addr = 5'd0; bus.wb_wr_data = 32'hFFFF_FFFF;
    bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_wr_addr = 5'd0;
    bus.mem_wr_en = 1'b1; bus.mem_wr_addr = 5'd0; bus.mem_wr_data = 32'h1234_5678;
    @(negedge clk);
    chk("r0_rd0", bus.rd_data[0 +: DW], 32'd0);
    chk("r0_rd1", bus.rd_data[DW +: DW], 32'd0);
    chk("r0_stall", {31'd0, bus.stall_req}, 32'd0);
    tick();
    chk("r0_array", dut.regs[0], 32'd0);

    // Saturation of the 4-bit counter while the 16-bit one keeps counting.
    idle();
    bus.rd_en = 2'b01;
    set_addr(0, 5'd9);
    bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_wr_addr = 5'd9;
    repeat (20) tick();
    @(negedge clk);
    chk("sat_cnt4", {28'd0, bus4.stall_cnt}, 32'd15);
    chk("sat_cnt16", {16'd0, bus.stall_cnt}, 32'd25);
    tick();
    tick();
    @(negedge clk);
    chk("sat_hold_cnt4", {28'd0, bus4.stall_cnt}, 32'd15);
    chk("sat_hold_cnt16", {16'd0, bus.stall_cnt}, 32'd27);

    // A WB write coinciding with reset is lost.
    idle();
    rst_n = 1'b1;
    bus.wb_wr_en = 1'b1; bus.wb_wr_addr = 5'd3; bus.wb_wr_data = 32'h0BAD_F00D;
    bus.rd_en = 2'b01;
    set_addr(0, 5'd3);
    @(negedge clk);
    chk("rstw_rd_in_reset", bus.rd_data[0 +: DW], 32'd0);
    tick();
    rst_n = 1'b0;
    bus.wb_wr_en = 1'b0;
    @(negedge clk);
    chk("rstw_lost", bus.rd_data[0 +: DW], 32'd0);
    chk("rstw_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    tick();

    // Random traffic on a narrow address range so stages collide often.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) == 0);
      bus.rd_en = NR'($urandom);
      for (int p = 0; p < NR; p++) set_addr(p, 5'($urandom_range(0, 7)));
      bus.ex_wr_en    = 1'($urandom);
      bus.ex_is_load  = ($urandom_range(0, 2) == 0);
      bus.ex_wr_addr  = 5'($urandom_range(0, 7));
      bus.ex_wr_data  = $urandom;
      bus.mem_wr_en   = 1'($urandom);
      bus.mem_wr_addr = 5'($urandom_range(0, 7));
      bus.mem_wr_data = $urandom;
      bus.wb_wr_en    = 1'($urandom);
      bus.wb_wr_addr  = 5'($urandom_range(0, 7));
      bus.wb_wr_data  = $urandom;
      @(negedge clk);
      model_check("rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
Parametrised register file for the MIPS pipeline, replacing the fixed two-port regs block. It has NUM_RD independent read ports and one write port, driven from the WB stage. Reads resolve EX→MEM→WB forwarding internally, so ID always sees the youngest value. It also detects load-use hazards, raises a stall request, and counts stall cycles for performance monitoring.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-high (codebase name kept; polarity/synchronicity fixed)
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
ex_wr_en  in  1  EX-stage instruction writes a register
ex_wr_addr  in  ADDR_W  EX destination
ex_wr_data  in  DATA_W  EX ALU result
ex_is_load  in  1  EX instruction is a load (data not yet available)
mem_wr_en  in  1  MEM-stage write enable
mem_wr_addr  in  ADDR_W  MEM destination
mem_wr_data  in  DATA_W  MEM result
wb_wr_en  in  1  WB write enable (commits to array)
wb_wr_addr  in  ADDR_W  WB destination
wb_wr_data  in  DATA_W  WB data
stall_req  out  1  load-use hazard; ID/IF must hold
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Storage: 2**ADDR_W x DATA_W registers. Write occurs on the clk edge when wb_wr_en=1, wb_wr_addr!=0 and rst_n=0.
- Register 0 is hardwired to zero: reads return 0, writes are dropped, it is never forwarded and never causes a stall.
- Reads are combinational, zero-latency. Per port i:
  - rd_en[i]=0 or addr=0 → 0.
  - Else the first match wins:
    - EX match (ex_wr_en, ex_wr_addr==addr, ex_is_load=0) → ex_wr_data.
    - MEM match (mem_wr_en, mem_wr_addr==addr) → mem_wr_data.
    - WB match (wb_wr_en, wb_wr_addr==addr) → wb_wr_data (same-cycle write-through).
    - Otherwise → array contents.
- EX match with ex_is_load=1 is not forwarded. The port falls through to the MEM/WB/array priority, giving a deterministic but stale value that the consumer discards because of the stall.
- stall_req = OR over ports of (rd_en[i] & addr!=0 & ex_wr_en & ex_is_load & ex_wr_addr==addr). Combinational, same cycle.
- stall_cnt: increments by 1 on each clk edge where stall_req=1 and rst_n=0. Holds at 2**CNT_W-1 (no wrap).
- Reset (rst_n=1 at edge): all array entries → 0, stall_cnt → 0. While rst_n=1, rd_data is all 0 and stall_req=0; writes are ignored.
- Reset asserted mid-stream: a WB write presented in the same cycle as reset is lost.
- Multiple ports reading the same address get identical data; there is no port interaction.
- EX, MEM and WB all targeting the same address: EX wins (if not a load), then MEM, then WB. The array still commits the WB value at the edge.

Test Plan:
- Reset then read: rst_n=1 for 2 cycles, then rd_en=all, addrs 1..NUM_RD → all rd_data=0, stall_cnt=0.
- WB write/readback: wb write r5=0xDEADBEEF.
  - Same cycle, port0 addr5 → 0xDEADBEEF (bypass).
  - Next cycle, wb_wr_en=0 → 0xDEADBEEF from array.
- Forward priority: r7 array=1, wb r7=2, mem r7=3, ex r7=4 (not load) → rd_data=4. Drop EX → 3. Drop MEM → 2.
- Load-use: ex_is_load=1, ex r9; port1 reads r9 → stall_req=1 for 3 held cycles, stall_cnt=3. Same setup with port reading r10 → stall_req=0.
- Zero register: wb write r0=0xFFFF_FFFF, ex r0 load → port read r0 gives 0, stall_req=0, array r0 stays 0.
- Saturation: CNT_W=4, hold stall 20 cycles → stall_cnt=15, then holds at 15.
